// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding, default width
// and the fill-counter sizing helper.
package pwm_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } pwm_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_MAX   = (1 << DEF_WIDTH) - 1;

   // Fill counter must hold 0 .. stages+1 inclusive.
   function automatic int fill_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous line plus a delayed copy used
// to derive single-cycle rise/fall strobes.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
         level_d <= sync_q[SYNC_STAGES-1];
      end
   end

   // Both edges see identical latency, so measured widths are exact.
   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~level_d;
   assign fall  = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a synchronized PWM line and
// flags stuck/over-range lines with a timeout pulse.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0]  CNT_LIMIT = '1;
   localparam int                FILL_W    = fill_width(SYNC_STAGES);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v == CNT_LIMIT) ? v : v + WIDTH'(1);
   endfunction

   logic s;
   logic rise;
   logic fall;

   pwm_state_t        state, state_nxt;
   logic [WIDTH-1:0]  cnt;
   logic [WIDTH-1:0]  hi_lat;
   logic [FILL_W-1:0] fill;
   logic              fill_done;
   logic              at_max;

   logic cnt_load;
   logic cnt_inc;
   logic hi_load;
   logic publish;
   logic expire;

   // ---- stage: input synchronization and edge detection ----
   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pwm_in),
      .level (s),
      .rise  (rise),
      .fall  (fall)
   );

   assign fill_done = (fill == FILL_DONE);
   assign at_max    = (cnt == CNT_LIMIT);

   // ---- stage: measurement FSM ----
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      hi_load   = 1'b0;
      publish   = 1'b0;
      expire    = 1'b0;
      case (state)
         // Wait for the synchronizer to fill and the line to be low, so a
         // line already high at reset release cannot look like a rise.
         S_IDLE: begin
            if (fill_done && !s) state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (rise) begin
               cnt_load  = 1'b1;
               state_nxt = S_HIGH;
            end
         end
         S_HIGH: begin
            if (fall) begin
               hi_load   = 1'b1;
               cnt_inc   = 1'b1;
               state_nxt = S_LOW;
            end else if (at_max) begin
               expire    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_LOW: begin
            // An edge coinciding with saturation wins: period CNT_LIMIT is legal.
            if (rise) begin
               publish   = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = S_HIGH;
            end else if (at_max) begin
               expire    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- stage: counters and registered results ----
   always_ff @(posedge clk) begin
      if (reset) begin
         fill        <= '0;
         cnt         <= '0;
         hi_lat      <= '0;
         period      <= '0;
         high_time   <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         if (!fill_done) fill <= fill + FILL_W'(1);

         if (cnt_load)     cnt <= WIDTH'(1);
         else if (cnt_inc) cnt <= sat_inc(cnt);

         if (hi_load) hi_lat <= cnt;

         if (publish) begin
            period    <= cnt;
            high_time <= hi_lat;
         end
         valid   <= publish;
         timeout <= expire;

         if (expire) stuck_level <= s;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: random-phase PWM trains, expectations
// derived per period from high/low lengths, monitor compares on each event.
module tb_pwm_capture;

   localparam int LIMIT = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic       pwm_in;
   logic [7:0] period;
   logic [7:0] high_time;
   logic       valid;
   logic       timeout;
   logic       stuck_level;

   always #5 clk = ~clk;

   pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .period      (period),
      .high_time   (high_time),
      .valid       (valid),
      .timeout     (timeout),
      .stuck_level (stuck_level)
   );

   typedef struct {
      bit is_to;
      int per;
      int hi;
      bit lvl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   ph       = 3;

   // Reference model state, at the granularity of whole PWM periods.
   bit m_meas;   // previous period is being measured and ends at the next rise
   bit m_take;   // the next rise starts a measurement
   int m_h, m_l, m_per, m_hi;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_valid(input int p, input int h);
      exp_t e;
      e.is_to = 1'b0; e.per = p; e.hi = h; e.lvl = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic push_timeout(input bit lvl);
      exp_t e;
      e.is_to = 1'b1; e.per = m_per; e.hi = m_hi; e.lvl = lvl;
      exp_q.push_back(e);
   endtask

   // Called at every rise of the stimulus, with that period's high/low lengths.
   task automatic model_rise(input int h, input int l);
      if (m_meas) begin
         push_valid(m_h + m_l, m_h);
         m_per = m_h + m_l;
         m_hi  = m_h;
      end
      if (m_take) begin
         if (h + l > LIMIT) begin
            // Counter saturates LIMIT cycles after this rise.
            push_timeout(h > LIMIT);
            m_meas = 1'b0;
            // Re-arming needs a low seen while idle, before the next rise.
            m_take = (h > LIMIT) || (h + l >= LIMIT + 2);
         end else begin
            m_meas = 1'b1;
         end
      end else begin
         m_meas = 1'b0;
         m_take = 1'b1;
      end
      m_h = h;
      m_l = l;
   endtask

   task automatic drive(input logic lv, input int n);
      pwm_in = lv;
      repeat (n) begin
         @(posedge clk);
         #ph;
      end
   endtask

   task automatic pwm_period(input int h, input int l);
      model_rise(h, l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic train(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) pwm_period(h, l);
      pwm_period(h, 12);
   endtask

   task automatic do_reset(input logic lv);
      ph = $urandom_range(1, 8);
      @(posedge clk);
      #ph;
      check("drain_before_reset", exp_q.size(), 0);
      exp_q.delete();
      pwm_in = lv;
      reset  = 1'b1;
      @(posedge clk);
      #ph;
      reset = 1'b0;
      check("rst_period", int'(period), 0);
      check("rst_high_time", int'(high_time), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_stuck_level", int'(stuck_level), 0);
      m_meas = 1'b0;
      m_take = 1'b1;
      m_per  = 0;
      m_hi   = 0;
   endtask

   // Monitor: every valid/timeout pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (valid || timeout) begin
         check("valid_timeout_exclusive", int'(valid && timeout), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_event", int'({valid, timeout}), 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind_timeout", int'(timeout), int'(mon_e.is_to));
            check("period", int'(period), mon_e.per);
            check("high_time", int'(high_time), mon_e.hi);
            if (mon_e.is_to) check("stuck_level", int'(stuck_level), int'(mon_e.lvl));
         end
      end
   end

   initial begin
      reset  = 1'b1;
      pwm_in = 1'b0;
      m_meas = 1'b0;
      m_take = 1'b1;
      m_h = 0; m_l = 0; m_per = 0; m_hi = 0;
      repeat (3) @(posedge clk);
      #ph;
      reset = 1'b0;

      // Basic capture, H=3 L=5.
      do_reset(1'b0);
      drive(1'b0, 8);
      train(3, 5, 8);

      // Minimum pulse widths.
      do_reset(1'b0);
      drive(1'b0, 8);
      train(1, 1, 20);

      // Random periods within range.
      for (int k = 0; k < 3; k++) begin
         do_reset(1'b0);
         drive(1'b0, 8);
         for (int i = 0; i < int'($urandom_range(3, 6)); i++)
            pwm_period($urandom_range(1, 40), $urandom_range(1, 40));
         pwm_period($urandom_range(1, 20), 12);
      end

      // Range boundary: 255 publishes, 256 times out low.
      do_reset(1'b0);
      drive(1'b0, 8);
      pwm_period(100, 155);
      pwm_period(100, 155);
      pwm_period(100, 155);
      pwm_period(100, 156);
      pwm_period(5, 10);
      pwm_period(5, 10);
      pwm_period(5, 12);

      // Stuck high through reset stays idle, then locks.
      do_reset(1'b1);
      drive(1'b1, 300);
      drive(1'b0, 4);
      pwm_period(4, 4);
      pwm_period(4, 4);
      pwm_period(4, 12);

      // Stuck high after arming, then recovery.
      do_reset(1'b0);
      drive(1'b0, 8);
      pwm_period(5, 5);
      pwm_period(5, 5);
      pwm_period(300, 6);
      pwm_period(6, 3);
      pwm_period(6, 3);
      pwm_period(6, 12);

      // Reset in the middle of a high phase.
      do_reset(1'b0);
      drive(1'b0, 8);
      pwm_period(6, 4);
      pwm_period(6, 4);
      pwm_period(6, 4);
      model_rise(6, 4);
      drive(1'b1, 4);
      do_reset(1'b1);
      drive(1'b1, 5);
      drive(1'b0, 5);
      pwm_period(7, 3);
      pwm_period(7, 3);
      pwm_period(7, 12);

      do_reset(1'b0);
      drive(1'b0, 4);
      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
